wb_stage: RTL and testbench

Write-back stage of the RV32I pipeline: registers the results leaving the memory stage (MEM/WB pipeline register), formats load data from the data memory, selects the register-file write value, and drives the register-file write port. Its outputs double as the MEM/WB forwarding source for the hazard unit. It also keeps a retired-instruction counter.

---
 rtl/rv_wb_pkg.sv | 16 +
 rtl/wb_stage_load_formatter.sv | 42 ++++
 rtl/wb_stage.sv | 116 +++++++++++
 tb/tb_wb_stage.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/rv_wb_pkg.sv
// Shared constants for the RV32I write-back stage: load funct3 encodings
// and the bit positions inside the CRT_WB control field.
package rv_wb_pkg;

    // Load width / sign encodings carried in funct3
    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;

    // CRT_WB control bits
    localparam int WB_REGWRITE = 1;
    localparam int WB_MEMTOREG = 0;

endpackage

// File: rtl/wb_stage_load_formatter.sv
// Combinational load formatter: picks the byte/half/word addressed by the
// low address bits out of the memory word, extends it, and flags
// misaligned accesses and funct3 values that are not loads.
module load_formatter
    import rv_wb_pkg::*;
#(
    parameter int DATA_W = 32
) (
    input  logic [DATA_W-1:0] rdata,
    input  logic [1:0]        off,
    input  logic [2:0]        funct3,
    output logic [DATA_W-1:0] data,
    output logic              err
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    assign byte_sel = rdata[{off, 3'b000} +: 8];
    assign half_sel = rdata[{off[1], 4'b0000} +: 16];

    // Extension per width; a misaligned half still uses off[1] to pick its half
    always_comb begin
        data = rdata;
        err  = 1'b0;
        case (funct3)
            F3_LB:  data = {{(DATA_W-8){byte_sel[7]}}, byte_sel};
            F3_LBU: data = {{(DATA_W-8){1'b0}}, byte_sel};
            F3_LH: begin
                data = {{(DATA_W-16){half_sel[15]}}, half_sel};
                err  = off[0];
            end
            F3_LHU: begin
                data = {{(DATA_W-16){1'b0}}, half_sel};
                err  = off[0];
            end
            F3_LW:  err = (off != 2'b00);
            default: err = 1'b1;
        endcase
    end

endmodule

// File: rtl/wb_stage.sv
// RV32I write-back stage: MEM/WB pipeline register, load formatting,
// register-file write port and retired-instruction counter. All outputs
// come from registered state only.
module wb_stage
    import rv_wb_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              STALL,
    input  logic              FLUSH,
    input  logic              VALID_IN,
    input  logic [1:0]        CRT_WB_IN,
    input  logic [2:0]        FUNCT3_IN,
    input  logic [DATA_W-1:0] ALU_RESULT_IN,
    input  logic [DATA_W-1:0] READ_DATA_IN,
    input  logic [4:0]        RD_IN,
    output logic              REG_WE_OUT,
    output logic [4:0]        REG_WADDR_OUT,
    output logic [DATA_W-1:0] REG_WDATA_OUT,
    output logic              LOAD_ERR_OUT,
    output logic [CNT_W-1:0]  RETIRED_OUT
);

    // Flow control: VALID_IN marks an instruction offered by the memory
    // stage; it is taken at every edge without STALL. STALL holds the current
    // entry (it keeps writing the same value, retired once when it leaves);
    // FLUSH replaces the entry with a bubble and overrides STALL.

    logic              valid_q, valid_d;
    logic [1:0]        crt_wb_q, crt_wb_d;
    logic [2:0]        funct3_q, funct3_d;
    logic [DATA_W-1:0] alu_q, alu_d;
    logic [DATA_W-1:0] rdata_q, rdata_d;
    logic [4:0]        rd_q, rd_d;
    logic [CNT_W-1:0]  retired_q, retired_d;

    logic [DATA_W-1:0] fmt_data;
    logic              fmt_err;
    logic              load_err;

    // Next-state: flush clears, stall holds, otherwise capture; an entry retires as it leaves
    always_comb begin
        valid_d   = valid_q;
        crt_wb_d  = crt_wb_q;
        funct3_d  = funct3_q;
        alu_d     = alu_q;
        rdata_d   = rdata_q;
        rd_d      = rd_q;
        retired_d = retired_q;
        if (FLUSH) begin
            valid_d  = 1'b0;
            crt_wb_d = '0;
            funct3_d = '0;
            alu_d    = '0;
            rdata_d  = '0;
            rd_d     = '0;
        end else if (!STALL) begin
            valid_d  = VALID_IN;
            crt_wb_d = CRT_WB_IN;
            funct3_d = FUNCT3_IN;
            alu_d    = ALU_RESULT_IN;
            rdata_d  = READ_DATA_IN;
            rd_d     = RD_IN;
        end
        if (valid_q && (!STALL || FLUSH)) begin
            retired_d = retired_q + CNT_W'(1);
        end
    end

    // State register with synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q   <= 1'b0;
            crt_wb_q  <= '0;
            funct3_q  <= '0;
            alu_q     <= '0;
            rdata_q   <= '0;
            rd_q      <= '0;
            retired_q <= '0;
        end else begin
            valid_q   <= valid_d;
            crt_wb_q  <= crt_wb_d;
            funct3_q  <= funct3_d;
            alu_q     <= alu_d;
            rdata_q   <= rdata_d;
            rd_q      <= rd_d;
            retired_q <= retired_d;
        end
    end

    load_formatter #(
        .DATA_W(DATA_W)
    ) u_fmt (
        .rdata (rdata_q),
        .off   (alu_q[1:0]),
        .funct3(funct3_q),
        .data  (fmt_data),
        .err   (fmt_err)
    );

    assign load_err = valid_q & crt_wb_q[WB_MEMTOREG] & fmt_err;

    // Write port: x0 and faulting loads never write
    always_comb begin
        LOAD_ERR_OUT  = load_err;
        REG_WADDR_OUT = rd_q;
        REG_WDATA_OUT = crt_wb_q[WB_MEMTOREG] ? fmt_data : alu_q;
        REG_WE_OUT    = valid_q & crt_wb_q[WB_REGWRITE] & (rd_q != 5'd0) & ~load_err;
    end

    assign RETIRED_OUT = retired_q;

endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus randomized traffic checked
// against a behavioural model of the write-back rules. A second instance
// with a 4-bit counter shares all inputs and covers counter wrap.
module tb_wb_stage;

    // ---------------- clock / reset / signals ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst = 1'b1;
    logic        stall = 1'b0;
    logic        flush = 1'b0;
    logic        valid_in = 1'b0;
    logic [1:0]  crt = 2'b00;
    logic [2:0]  f3 = 3'b000;
    logic [31:0] alu = '0;
    logic [31:0] rdata = '0;
    logic [4:0]  rd = '0;

    logic        we, lerr, we4, lerr4;
    logic [4:0]  waddr, waddr4;
    logic [31:0] wdata, wdata4;
    logic [31:0] retired;
    logic [3:0]  retired4;

    wb_stage #(.DATA_W(32), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .STALL(stall), .FLUSH(flush), .VALID_IN(valid_in),
        .CRT_WB_IN(crt), .FUNCT3_IN(f3), .ALU_RESULT_IN(alu), .READ_DATA_IN(rdata),
        .RD_IN(rd), .REG_WE_OUT(we), .REG_WADDR_OUT(waddr), .REG_WDATA_OUT(wdata),
        .LOAD_ERR_OUT(lerr), .RETIRED_OUT(retired)
    );

    wb_stage #(.DATA_W(32), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .STALL(stall), .FLUSH(flush), .VALID_IN(valid_in),
        .CRT_WB_IN(crt), .FUNCT3_IN(f3), .ALU_RESULT_IN(alu), .READ_DATA_IN(rdata),
        .RD_IN(rd), .REG_WE_OUT(we4), .REG_WADDR_OUT(waddr4), .REG_WDATA_OUT(wdata4),
        .LOAD_ERR_OUT(lerr4), .RETIRED_OUT(retired4)
    );

    int n_tests = 0;
    int n_fail  = 0;

    // ---------------- reference model ----------------
    // The model holds "the instruction currently in write-back" and derives
    // the expected write from the architectural load rules.
    bit          m_valid, m_rw, m_mtr;
    int unsigned m_f3, m_rd;
    logic [31:0] m_alu, m_rdata;
    logic [31:0] m_ret;

    logic [31:0] exp_q[$];

    function automatic void model_expect(output bit e_we, output bit e_err,
                                         output logic [31:0] e_data, output bit known);
        int unsigned off, b, h;
        bit mis, illegal;
        logic [31:0] ld;
        off = m_alu % 4;
        b = (m_rdata >> (8 * off)) & 32'hFF;
        h = ((off >= 2) ? (m_rdata >> 16) : m_rdata) & 32'hFFFF;
        mis = 0;
        illegal = 0;
        ld = '0;
        case (m_f3)
            0: ld = (b >= 128) ? b + 32'hFFFF_FF00 : b;
            4: ld = b;
            1: begin ld = (h >= 32768) ? h + 32'hFFFF_0000 : h; mis = (off % 2 == 1); end
            5: begin ld = h; mis = (off % 2 == 1); end
            2: begin ld = m_rdata; mis = (off != 0); end
            default: illegal = 1;
        endcase
        e_err  = m_valid && m_mtr && (mis || illegal);
        e_we   = m_valid && m_rw && (m_rd != 0) && !e_err;
        e_data = m_mtr ? ld : m_alu;
        known  = !(m_mtr && illegal);
    endfunction

    task automatic model_edge();
        if (rst) begin
            m_valid = 0; m_rw = 0; m_mtr = 0; m_f3 = 0; m_rd = 0;
            m_alu = '0; m_rdata = '0; m_ret = '0;
        end else begin
            if (m_valid && (!stall || flush)) m_ret = m_ret + 1;
            if (flush) begin
                m_valid = 0; m_rw = 0; m_mtr = 0; m_f3 = 0; m_rd = 0;
                m_alu = '0; m_rdata = '0;
            end else if (!stall) begin
                m_valid = valid_in; m_rw = crt[1]; m_mtr = crt[0];
                m_f3 = f3; m_rd = rd; m_alu = alu; m_rdata = rdata;
            end
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    task automatic drive(input bit v, input logic [1:0] c, input logic [2:0] f,
                         input logic [31:0] a, input logic [31:0] d, input logic [4:0] r);
        valid_in = v; crt = c; f3 = f; alu = a; rdata = d; rd = r;
    endtask

    task automatic idle();
        drive(0, 2'b00, 3'b000, 32'h0, 32'h0, 5'd0);
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        idle();
        tick(); tick();
        n_tests++;
        if ({we, lerr, waddr, wdata} !== 39'd0) begin
            n_fail++;
            $display("FAIL reset_outputs: we=%b err=%b addr=%0d data=%h, required all 0", we, lerr, waddr, wdata);
        end
        n_tests++;
        if (retired !== 32'd0 || retired4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_retired: %0d/%0d, required 0/0", retired, retired4);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu_op();
        drive(1, 2'b10, 3'b000, 32'h0000_1234, 32'h0, 5'd5);
        tick();
        idle();
        n_tests++;
        if (we !== 1'b1 || waddr !== 5'd5 || wdata !== 32'h0000_1234) begin
            n_fail++;
            $display("FAIL alu_write: we=%b addr=%0d data=%h, required 1/5/00001234", we, waddr, wdata);
        end
        n_tests++;
        if (retired !== 32'd0) begin
            n_fail++;
            $display("FAIL alu_retired_before: %0d, required 0", retired);
        end
        tick();
        n_tests++;
        if (retired !== 32'd1) begin
            n_fail++;
            $display("FAIL alu_retired_after: %0d, required 1", retired);
        end
    endtask

    task automatic test_loads();
        logic [2:0]  tf3 [7] = '{3'b000, 3'b100, 3'b001, 3'b101, 3'b010, 3'b000, 3'b101};
        logic [1:0]  toff[7] = '{2'd2, 2'd3, 2'd2, 2'd0, 2'd0, 2'd3, 2'd2};
        logic [31:0] texp[7] = '{32'hFFFF_FFFF, 32'h0000_0080, 32'hFFFF_80FF, 32'h0000_7F01,
                                 32'h80FF_7F01, 32'hFFFF_FF80, 32'h0000_80FF};
        for (int i = 0; i < 7; i++) begin
            drive(1, 2'b11, tf3[i], 32'h0000_2000 + 32'(toff[i]), 32'h80FF_7F01, 5'd7);
            tick();
            n_tests++;
            if (we !== 1'b1 || lerr !== 1'b0 || wdata !== texp[i]) begin
                n_fail++;
                $display("FAIL load_%0d: we=%b err=%b data=%h, required 1/0/%h", i, we, lerr, wdata, texp[i]);
            end
        end
        idle();
        tick();
    endtask

    task automatic test_errors();
        logic [31:0] r0;
        r0 = retired;
        drive(1, 2'b11, 3'b010, 32'h0000_3002, 32'h1234_5678, 5'd8);
        tick();
        n_tests++;
        if (lerr !== 1'b1 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL lw_misaligned: err=%b we=%b, required 1/0", lerr, we);
        end
        drive(1, 2'b11, 3'b011, 32'h0000_3000, 32'h1234_5678, 5'd8);
        tick();
        n_tests++;
        if (lerr !== 1'b1 || we !== 1'b0) begin
            n_fail++;
            $display("FAIL illegal_funct3: err=%b we=%b, required 1/0", lerr, we);
        end
        drive(1, 2'b10, 3'b000, 32'hDEAD_BEEF, 32'h0, 5'd0);
        tick();
        n_tests++;
        if (we !== 1'b0 || lerr !== 1'b0) begin
            n_fail++;
            $display("FAIL x0_write: we=%b err=%b, required 0/0", we, lerr);
        end
        idle();
        tick();
        n_tests++;
        if (retired !== r0 + 32'd3) begin
            n_fail++;
            $display("FAIL error_retire_count: %0d, required %0d", retired, r0 + 32'd3);
        end
    endtask

    task automatic test_stall_flush();
        logic [31:0] r0;
        r0 = retired;
        drive(1, 2'b10, 3'b000, 32'h0000_ABCD, 32'h0, 5'd9);
        tick();
        stall = 1'b1;
        drive(1, 2'b10, 3'b000, 32'h0000_5555, 32'h0, 5'd3);
        for (int i = 0; i < 3; i++) begin
            tick();
            n_tests++;
            if (we !== 1'b1 || waddr !== 5'd9 || wdata !== 32'h0000_ABCD || retired !== r0) begin
                n_fail++;
                $display("FAIL stall_hold_%0d: we=%b addr=%0d data=%h ret=%0d, required 1/9/0000abcd/%0d",
                         i, we, waddr, wdata, retired, r0);
            end
        end
        stall = 1'b0;
        tick();
        n_tests++;
        if (retired !== r0 + 32'd1 || waddr !== 5'd3 || wdata !== 32'h0000_5555) begin
            n_fail++;
            $display("FAIL stall_release: ret=%0d addr=%0d data=%h, required %0d/3/00005555",
                     retired, waddr, wdata, r0 + 32'd1);
        end
        stall = 1'b1;
        flush = 1'b1;
        tick();
        n_tests++;
        if (we !== 1'b0 || waddr !== 5'd0 || wdata !== 32'h0 || retired !== r0 + 32'd2) begin
            n_fail++;
            $display("FAIL flush_over_stall: we=%b addr=%0d data=%h ret=%0d, required 0/0/0/%0d",
                     we, waddr, wdata, retired, r0 + 32'd2);
        end
        stall = 1'b0;
        flush = 1'b0;
        idle();
    endtask

    task automatic test_reset_mid();
        for (int i = 0; i < 3; i++) begin
            drive(1, 2'b10, 3'b000, 32'h100 + 32'(i), 32'h0, 5'(10 + i));
            tick();
        end
        rst = 1'b1;
        stall = 1'b1;
        tick();
        n_tests++;
        if ({we, lerr, waddr, wdata} !== 39'd0 || retired !== 32'd0 || retired4 !== 4'd0) begin
            n_fail++;
            $display("FAIL reset_mid: we=%b err=%b addr=%0d data=%h ret=%0d/%0d, required all 0",
                     we, lerr, waddr, wdata, retired, retired4);
        end
        rst = 1'b0;
        stall = 1'b0;
        idle();
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 16; i++) begin
            drive(1, 2'b10, 3'b000, 32'(i), 32'h0, 5'd1);
            tick();
        end
        idle();
        n_tests++;
        if (retired4 !== 4'd15 || retired !== 32'd15) begin
            n_fail++;
            $display("FAIL wrap_preload: %0d/%0d, required 15/15", retired4, retired);
        end
        tick();
        n_tests++;
        if (retired4 !== 4'd0 || retired !== 32'd16) begin
            n_fail++;
            $display("FAIL wrap_16th: %0d/%0d, required 0/16", retired4, retired);
        end
    endtask

    task automatic test_random();
        bit e_we, e_err, known;
        logic [31:0] e_data, got;
        for (int i = 0; i < 400; i++) begin
            rst   = ($urandom_range(0, 59) == 0);
            stall = ($urandom_range(0, 3) == 0);
            flush = ($urandom_range(0, 9) == 0);
            drive($urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)), 3'($urandom_range(0, 7)),
                  $urandom, $urandom, 5'($urandom_range(0, 31)));
            tick();
            model_expect(e_we, e_err, e_data, known);
            if (e_we) exp_q.push_back(e_data);
            n_tests++;
            if (we !== e_we || lerr !== e_err || waddr !== 5'(m_rd)) begin
                n_fail++;
                $display("FAIL rand_ctrl_%0d: we=%b err=%b addr=%0d, required %b/%b/%0d",
                         i, we, lerr, waddr, e_we, e_err, m_rd);
            end
            if (known) begin
                n_tests++;
                if (wdata !== e_data) begin
                    n_fail++;
                    $display("FAIL rand_data_%0d: %h, required %h", i, wdata, e_data);
                end
            end
            n_tests++;
            if (retired !== m_ret || retired4 !== m_ret[3:0] || we4 !== e_we || lerr4 !== e_err
                || waddr4 !== waddr || wdata4 !== wdata) begin
                n_fail++;
                $display("FAIL rand_count_%0d: ret=%0d ret4=%0d, required %0d/%0d",
                         i, retired, retired4, m_ret, m_ret[3:0]);
            end
            if (we === 1'b1) begin
                n_tests++;
                if (exp_q.size() == 0) begin
                    n_fail++;
                    $display("FAIL rand_sb_%0d: write of %h, required no write", i, wdata);
                end else begin
                    got = exp_q.pop_front();
                    if (wdata !== got) begin
                        n_fail++;
                        $display("FAIL rand_sb_%0d: wrote %h, required %h", i, wdata, got);
                    end
                end
            end
        end
        n_tests++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL rand_sb_drain: %0d writes missing, required 0", exp_q.size());
        end
        rst = 1'b0; stall = 1'b0; flush = 1'b0;
        idle();
    endtask

    // ---------------- sequence and report ----------------
    initial begin
        test_reset();
        test_alu_op();
        test_loads();
        test_errors();
        test_stall_flush();
        test_reset_mid();
        test_wrap();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
